// File: rtl/aemb_iwb_iram.sv
// Instruction-side Wishbone responder serving 32-bit words from on-chip RAM,
// with WAIT programmable wait states and a loader write port for program download.
module aemb_iwb_iram #(
  parameter int AW   = 11,
  parameter int WAIT = 0
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic [31:0]   iwb_adr_i,
  input  logic          iwb_stb_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_adr_i,
  input  logic [31:0]   ld_dat_i,
  output logic          ld_busy_o,
  output logic [15:0]   fetch_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [2:0] WAIT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  logic [31:0]   ram [0:(1<<AW)-1];

  state_t        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [2:0]    wait_q, wait_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [31:0]   dat_q;

  logic          rd_en;
  logic [AW-1:0] rd_adr;
  logic [AW-1:0] fetch_adr;
  logic          new_req;
  logic          unused_adr_bits;

  // Only the word-address bits select a RAM entry; the rest alias.
  assign fetch_adr       = iwb_adr_i[AW+1:2];
  assign unused_adr_bits = ^{iwb_adr_i[31:AW+2], iwb_adr_i[1:0]};
  assign new_req         = iwb_stb_i & ~ld_we_i;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wait_d  = wait_q;
    rd_en   = 1'b0;
    rd_adr  = adr_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_ACK: begin
        if (new_req) begin
          adr_d = fetch_adr;
          if (WAIT == 0) begin
            state_d = S_ACK;
            rd_en   = 1'b1;
            rd_adr  = fetch_adr;
          end else begin
            state_d = S_WAIT;
            wait_d  = WAIT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // Re-reading on the last wait cycle picks up any loader write made meanwhile.
        if (wait_q == 3'd0) begin
          state_d = S_ACK;
          rd_en   = 1'b1;
          rd_adr  = adr_q;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ack_d  = (state_d == S_ACK);
    busy_d = (state_d != S_IDLE);
    if (ack_d) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      wait_q  <= 3'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write port: no reset so the array maps onto block RAM.
  always_ff @(posedge gclk) begin
    if (ld_we_i) begin
      ram[ld_adr_i] <= ld_dat_i;
    end
  end

  // Read register doubles as the output holding register (read-before-write).
  always_ff @(posedge gclk) begin
    if (grst) begin
      dat_q <= 32'h0;
    end else if (rd_en) begin
      dat_q <= ram[rd_adr];
    end
  end

  assign iwb_dat_o   = dat_q;
  assign iwb_ack_o   = ack_q;
  assign ld_busy_o   = busy_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_aemb_iwb_iram.sv
// Randomised self-checking bench: three responders (WAIT 0, 2, 3) share one stimulus
// stream and are compared every cycle against a countdown-based transaction model.
module tb_aemb_iwb_iram;
  localparam int AW = 11;
  localparam int NI = 3;

  logic          gclk = 1'b0;
  logic          grst;
  logic [31:0]   iwb_adr;
  logic          stb;
  logic          ld_we;
  logic [AW-1:0] ld_adr;
  logic [31:0]   ld_dat;

  logic [31:0]   dat_o  [NI];
  logic          ack_o  [NI];
  logic          busy_o [NI];
  logic [15:0]   cnt_o  [NI];

  always #5 gclk = ~gclk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      aemb_iwb_iram #(.AW(AW), .WAIT(gi == 0 ? 0 : gi + 1)) u_dut (
        .gclk        (gclk),
        .grst        (grst),
        .iwb_adr_i   (iwb_adr),
        .iwb_stb_i   (stb),
        .iwb_dat_o   (dat_o[gi]),
        .iwb_ack_o   (ack_o[gi]),
        .ld_we_i     (ld_we),
        .ld_adr_i    (ld_adr),
        .ld_dat_i    (ld_dat),
        .ld_busy_o   (busy_o[gi]),
        .fetch_cnt_o (cnt_o[gi])
      );
    end
  endgenerate

  // Reference model: memory image plus one outstanding transaction per instance.
  logic [31:0] mmem   [64];
  bit          m_busy [NI];
  int          m_left [NI];
  int          m_addr [NI];
  bit          e_ack  [NI];
  logic [31:0] e_dat  [NI];
  bit          e_busy [NI];
  logic [15:0] e_cnt  [NI];

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  function automatic logic [31:0] rand_adr();
    logic [31:0] a;
    a = $urandom();
    a[AW+1:2] = 11'($urandom_range(0, 63));
    return a;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %08h expected %08h", name, k, act, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      bit          na;
      logic [31:0] nd;
      na = 1'b0;
      nd = e_dat[k];
      if (grst) begin
        m_busy[k] = 1'b0;
        m_left[k] = 0;
        e_ack[k]  = 1'b0;
        e_dat[k]  = 32'h0;
        e_busy[k] = 1'b0;
        e_cnt[k]  = 16'h0;
      end else begin
        if (m_busy[k] && !e_ack[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            na = 1'b1;
            nd = mmem[m_addr[k]];
          end
        end else begin
          m_busy[k] = 1'b0;
          if (stb && !ld_we) begin
            m_busy[k] = 1'b1;
            m_addr[k] = int'(iwb_adr[AW+1:2]);
            m_left[k] = wait_of(k);
            if (m_left[k] == 0) begin
              na = 1'b1;
              nd = mmem[m_addr[k]];
            end
          end
        end
        e_ack[k]  = na;
        e_dat[k]  = nd;
        e_busy[k] = m_busy[k];
        if (na) e_cnt[k] = e_cnt[k] + 16'd1;
      end
    end
    if (ld_we) mmem[int'(ld_adr)] = ld_dat;
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk("ack",  k, 32'(ack_o[k]),  32'(e_ack[k]));
      chk("dat",  k, dat_o[k],       e_dat[k]);
      chk("busy", k, 32'(busy_o[k]), 32'(e_busy[k]));
      chk("cnt",  k, 32'(cnt_o[k]),  32'(e_cnt[k]));
    end
    if (verbose && ack_o[0] === 1'b1)
      $display("ack inst0 t=%0t dat=%08h cnt=%0d", $time, dat_o[0], cnt_o[0]);
  endtask

  task automatic tick();
    model_step();
    @(posedge gclk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    stb   = 1'b0;
    ld_we = 1'b0;
    repeat (n) tick();
  endtask

  task automatic load(input int a, input logic [31:0] d);
    stb    = 1'b0;
    ld_we  = 1'b1;
    ld_adr = AW'(a);
    ld_dat = d;
    tick();
    ld_we  = 1'b0;
  endtask

  logic [31:0] words [4];
  int acks2;

  initial begin
    words[0] = 32'hB0000000;
    words[1] = 32'h88000000;
    words[2] = 32'hB9CE0010;
    words[3] = 32'h12345678;
    grst = 1'b1; stb = 1'b0; ld_we = 1'b0; iwb_adr = 32'h0; ld_adr = '0; ld_dat = 32'h0;
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = 1'b0; m_left[k] = 0; m_addr[k] = 0;
      e_ack[k] = 1'b0; e_dat[k] = 32'h0; e_busy[k] = 1'b0; e_cnt[k] = 16'h0;
    end
    #1;

    // Power-up reset.
    repeat (3) tick();
    for (int k = 0; k < NI; k++) begin
      chk("rst_ack", k, 32'(ack_o[k]), 32'h0);
      chk("rst_dat", k, dat_o[k], 32'h0);
      chk("rst_cnt", k, 32'(cnt_o[k]), 32'h0);
    end
    grst = 1'b0;
    idle(2);

    // Program the window: known words at 0..3, random elsewhere.
    for (int a = 0; a < 64; a++) load(a, (a < 4) ? words[a] : $urandom());

    // Back-to-back streaming with WAIT=0.
    stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iwb_adr = 32'(i * 4);
      tick();
      chk("stream_ack", 0, 32'(ack_o[0]), 32'h1);
      chk("stream_dat", 0, dat_o[0], words[i]);
    end
    chk("stream_cnt", 0, 32'(cnt_o[0]), 32'd4);
    idle(1);
    chk("hold_ack", 0, 32'(ack_o[0]), 32'h0);
    chk("hold_dat", 0, dat_o[0], 32'h12345678);
    idle(8);

    // Single fetch at 0x8 with WAIT=2: busy for three cycles, ack on the third.
    stb = 1'b1; iwb_adr = 32'h8;
    tick();
    stb = 1'b0;
    chk("w2_busy1", 1, 32'(busy_o[1]), 32'h1);
    chk("w2_ack1",  1, 32'(ack_o[1]),  32'h0);
    tick();
    chk("w2_busy2", 1, 32'(busy_o[1]), 32'h1);
    chk("w2_ack2",  1, 32'(ack_o[1]),  32'h0);
    tick();
    chk("w2_busy3", 1, 32'(busy_o[1]), 32'h1);
    chk("w2_ack3",  1, 32'(ack_o[1]),  32'h1);
    chk("w2_dat3",  1, dat_o[1], 32'hB9CE0010);
    tick();
    chk("w2_busy4", 1, 32'(busy_o[1]), 32'h0);
    chk("w2_ack4",  1, 32'(ack_o[1]),  32'h0);
    idle(6);

    // Reset while the WAIT=3 instance is mid-wait: the fetch must vanish.
    stb = 1'b1; iwb_adr = 32'h8;
    tick();
    stb = 1'b0;
    tick();
    grst = 1'b1;
    repeat (3) tick();
    chk("abort_ack",  2, 32'(ack_o[2]),  32'h0);
    chk("abort_dat",  2, dat_o[2],       32'h0);
    chk("abort_cnt",  2, 32'(cnt_o[2]),  32'h0);
    chk("abort_busy", 2, 32'(busy_o[2]), 32'h0);
    grst = 1'b0;
    acks2 = 0;
    repeat (6) begin
      tick();
      if (ack_o[2] === 1'b1) acks2++;
    end
    chk("abort_noack", 2, 32'(acks2), 32'h0);

    // Loader collides with a fetch request in IDLE: the fetch retries next cycle.
    stb = 1'b1; iwb_adr = 32'h10;
    ld_we = 1'b1; ld_adr = AW'(4); ld_dat = 32'hCAFEF00D;
    tick();
    chk("coll_ack",  0, 32'(ack_o[0]),  32'h0);
    chk("coll_busy", 0, 32'(busy_o[0]), 32'h0);
    ld_we = 1'b0;
    tick();
    chk("coll_retry_ack", 0, 32'(ack_o[0]), 32'h1);
    chk("coll_retry_dat", 0, dat_o[0], 32'hCAFEF00D);
    idle(6);

    // Address aliasing: upper and byte-lane bits are ignored.
    stb = 1'b1;
    iwb_adr = 32'h2000;     tick(); chk("alias_2000", 0, dat_o[0], 32'hB0000000);
    iwb_adr = 32'h3;        tick(); chk("alias_0003", 0, dat_o[0], 32'hB0000000);
    iwb_adr = 32'hFFFFE00C; tick(); chk("alias_high", 0, dat_o[0], 32'h12345678);
    idle(6);

    // Randomised traffic: strobes, loader writes, occasional resets.
    verbose = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      grst    = ($urandom_range(0, 99) == 0);
      stb     = ($urandom_range(0, 9) < 7);
      ld_we   = ($urandom_range(0, 4) == 0);
      ld_adr  = AW'($urandom_range(0, 63));
      ld_dat  = $urandom();
      iwb_adr = rand_adr();
      tick();
    end
    grst = 1'b1; stb = 1'b0; ld_we = 1'b0;
    repeat (2) tick();
    grst = 1'b0;
    idle(1);

    // Counter wrap: 65536 consecutive WAIT=0 acks bring the count back to zero.
    stb = 1'b1;
    for (int n = 1; n <= 65536; n++) begin
      iwb_adr = rand_adr();
      tick();
      if (n == 65535) chk("wrap_ffff", 0, 32'(cnt_o[0]), 32'h0000FFFF);
      if (n == 65536) chk("wrap_zero", 0, 32'(cnt_o[0]), 32'h0);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
